// File: rtl/zoom_hdmi_pkg.sv
// Shared types and 720p default timing for the zoom-to-HDMI pixel output path.
package zoom_hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  typedef logic [23:0] pixel_t;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

endpackage

// File: rtl/zoom_hdmi_timing_cnt.sv
// Raster h/v counters with wrap, plus combinational hs/vs/de and zoom-window decode.
module zoom_hdmi_timing_cnt
  import zoom_hdmi_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_720P,
  parameter int   H_FP     = H_FP_720P,
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BP     = H_BP_720P,
  parameter int   V_ACTIVE = V_ACTIVE_720P,
  parameter int   V_FP     = V_FP_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BP     = V_BP_720P,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   WIN_X    = 320,
  parameter int   WIN_Y    = 180,
  parameter int   WIN_W    = 640,
  parameter int   WIN_H    = 360,
  parameter int   CNT_W    = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic hs,
  output logic vs,
  output logic de,
  output logic in_win,
  output logic frame_last,
  output logic req_pt
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] WX_LO    = CNT_W'(WIN_X);
  localparam logic [CNT_W-1:0] WX_HI    = CNT_W'(WIN_X + WIN_W);
  localparam logic [CNT_W-1:0] WY_LO    = CNT_W'(WIN_Y);
  localparam logic [CNT_W-1:0] WY_HI    = CNT_W'(WIN_Y + WIN_H);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  // counters sit at 0 outside RUN so the first RUN cycle is h=0, v=0
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + 1'b1;
      end
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    hs         = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
    vs         = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
    de         = (h_q < H_ACT) && (v_q < V_ACT);
    in_win     = de && (h_q >= WX_LO) && (h_q < WX_HI) && (v_q >= WY_LO) && (v_q < WY_HI);
    frame_last = (h_q == H_LAST) && (v_q == V_LAST);
    req_pt     = (h_q == '0) && (v_q == V_LAST);
  end

endmodule

// File: rtl/zoom_hdmi_pixel_out.sv
// HDMI pixel output stage: pops zoomed pixels inside the window, fills background elsewhere.
// Optional saturating underflow counter port enabled by ZOOM_HDMI_UNDERFLOW_CNT_EN.
module zoom_hdmi_pixel_out
  import zoom_hdmi_pkg::*;
#(
  parameter int     H_ACTIVE = H_ACTIVE_720P,
  parameter int     H_FP     = H_FP_720P,
  parameter int     H_SYNC   = H_SYNC_720P,
  parameter int     H_BP     = H_BP_720P,
  parameter int     V_ACTIVE = V_ACTIVE_720P,
  parameter int     V_FP     = V_FP_720P,
  parameter int     V_SYNC   = V_SYNC_720P,
  parameter int     V_BP     = V_BP_720P,
  parameter logic   HS_POL   = 1'b1,
  parameter logic   VS_POL   = 1'b1,
  parameter int     WIN_X    = 320,
  parameter int     WIN_Y    = 180,
  parameter int     WIN_W    = 640,
  parameter int     WIN_H    = 360,
  parameter pixel_t BG_COLOR = 24'h000000,
  parameter int     CNT_W    = 12
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        en,
  input  logic        rd_vld,
  input  logic [23:0] rd_data,
  output logic        rd_en,
  output logic        frame_req,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [23:0] rgb,
  output logic        underflow
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  state_e state_q, state_d;
  logic   hs_s, vs_s, de_s, win_s, frame_last_s, req_pt_s, uf_hit_s;
  logic   hs_q, hs_d, vs_q, vs_d, de_q, de_d, frame_req_q, frame_req_d;
  logic   underflow_q, underflow_d;
  pixel_t rgb_q, rgb_d;

  zoom_hdmi_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_W(WIN_W), .WIN_H(WIN_H),
    .CNT_W(CNT_W)
  ) u_timing (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .run       (state_q == RUN),
    .hs        (hs_s),
    .vs        (vs_s),
    .de        (de_s),
    .in_win    (win_s),
    .frame_last(frame_last_s),
    .req_pt    (req_pt_s)
  );

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // a frame, once started, always runs to its last pixel before en is honoured
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? PRIME : IDLE;
      PRIME:   state_d = rd_vld ? RUN : PRIME;
      RUN:     state_d = (frame_last_s && !en) ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hs_d        = ~HS_POL;
    vs_d        = ~VS_POL;
    de_d        = 1'b0;
    rgb_d       = '0;
    rd_en       = 1'b0;
    frame_req_d = 1'b0;
    uf_hit_s    = 1'b0;
    case (state_q)
      IDLE:  frame_req_d = en;
      PRIME: frame_req_d = 1'b0;
      RUN: begin
        hs_d        = hs_s;
        vs_d        = vs_s;
        de_d        = de_s;
        rd_en       = win_s && rd_vld;
        frame_req_d = req_pt_s && en;
        uf_hit_s    = win_s && !rd_vld;
        // a missing pixel is replaced by background, never stalled
        if (win_s) begin
          rgb_d = rd_vld ? rd_data : BG_COLOR;
        end else if (de_s) begin
          rgb_d = BG_COLOR;
        end else begin
          rgb_d = '0;
        end
      end
      default: frame_req_d = 1'b0;
    endcase
    underflow_d = underflow_q || uf_hit_s;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      rgb_q       <= '0;
      frame_req_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      frame_req_q <= frame_req_d;
      underflow_q <= underflow_d;
    end
  end

  assign hs        = hs_q;
  assign vs        = vs_q;
  assign de        = de_q;
  assign rgb       = rgb_q;
  assign frame_req = frame_req_q;
  assign underflow = underflow_q;

`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  always_comb begin
    if (uf_hit_s && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end else begin
      uf_cnt_d = uf_cnt_q;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      uf_cnt_q <= 16'd0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_zoom_hdmi_pixel_out.sv
// Directed bench for zoom_hdmi_pixel_out on a 14x7 raster with a 4x2 window at (2,1).
module tb_zoom_hdmi_pixel_out;

  localparam logic [23:0] BG = 24'h101010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rd_vld = 1'b0;
  logic [23:0] rd_data = 24'd0;
  logic        rd_en, frame_req, hs, vs, de, underflow;
  logic [23:0] rgb;
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
  logic [15:0] cnt_log [0:255];
`endif

  zoom_hdmi_pixel_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .WIN_X(2), .WIN_Y(1), .WIN_W(4), .WIN_H(2),
    .BG_COLOR(24'h101010), .CNT_W(12)
  ) dut (
    .rd_clk(clk), .rd_rst(rst), .en(en), .rd_vld(rd_vld), .rd_data(rd_data),
    .rd_en(rd_en), .frame_req(frame_req), .hs(hs), .vs(vs), .de(de),
    .rgb(rgb), .underflow(underflow)
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int idx = 0;
  int fifo_data = 0;
  logic [23:0] rgb_log [0:255];
  logic        hs_log [0:255], vs_log [0:255], de_log [0:255];
  logic        fr_log [0:255], ren_log [0:255], uf_log [0:255];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: log outputs at negedge, advance the FIFO model after the edge
  task automatic cyc();
    logic pop;
    @(negedge clk);
    pop = rd_en;
    if (idx < 256) begin
      rgb_log[idx] = rgb; hs_log[idx] = hs; vs_log[idx] = vs; de_log[idx] = de;
      fr_log[idx] = frame_req; ren_log[idx] = rd_en; uf_log[idx] = underflow;
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
      cnt_log[idx] = underflow_cnt;
`endif
    end
    idx++;
    @(posedge clk);
    #1;
    if (pop) begin
      fifo_data++;
      rd_data = 24'(fifo_data);
    end
  endtask

  function automatic int count(input int sel, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0: n += int'(fr_log[i]);
        1: n += int'(ren_log[i]);
        2: n += int'(de_log[i]);
        default: n += int'(hs_log[i] | vs_log[i] | de_log[i] | ren_log[i] | fr_log[i] | (rgb_log[i] != 24'd0));
      endcase
    end
    return n;
  endfunction

  logic [23:0] line1_exp [0:7];
  logic [23:0] line2_exp [0:7];

  initial begin
    line1_exp = '{BG, BG, 24'd1, 24'd2, 24'd3, 24'd4, BG, BG};
    line2_exp = '{BG, BG, 24'd5, 24'd6, 24'd7, 24'd8, BG, BG};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hs", 32'(hs), 32'd0);
    check_eq("rst_vs", 32'(vs), 32'd0);
    check_eq("rst_de", 32'(de), 32'd0);
    check_eq("rst_rgb", 32'(rgb), 32'd0);
    check_eq("rst_frame_req", 32'(frame_req), 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b1;

    // PRIME without data: one request, outputs idle
    idx = 0;
    repeat (6) cyc();
    check_eq("prime_fr_pulse_at_1", 32'(fr_log[1]), 32'd1);
    check_eq("prime_fr_count", 32'(count(0, 0, 5)), 32'd1);
    check_eq("prime_activity", 32'(count(3, 0, 0) + count(1, 0, 5) + count(2, 0, 5)), 32'd0);

    // streaming: output index j reflects counter step k = j-2
    fifo_data = 1;
    rd_data = 24'd1;
    idx = 0;
    for (int j = 0; j < 236; j++) begin
      en     = !((j >= 130) && (j < 206));
      rd_vld = !((j == 116) || (j == 234) || ((j >= 206) && (j < 216)));
      cyc();
    end

    check_eq("first_de_k0", 32'(de_log[1]), 32'd0);
    check_eq("first_de", 32'(de_log[2]), 32'd1);
    check_eq("line0_bg", 32'(rgb_log[2]), 32'(BG));
    check_eq("blank_rgb", 32'(rgb_log[10]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("line1_rgb%0d", k), 32'(rgb_log[16 + k]), 32'(line1_exp[k]));
      check_eq($sformatf("line2_rgb%0d", k), 32'(rgb_log[30 + k]), 32'(line2_exp[k]));
    end
    check_eq("pops_frame1", 32'(count(1, 1, 98)), 32'd8);
    check_eq("de_frame1", 32'(count(2, 2, 99)), 32'd32);
    check_eq("hs_h9", 32'(hs_log[11]), 32'd0);
    check_eq("hs_h10", 32'(hs_log[12]), 32'd1);
    check_eq("hs_h11", 32'(hs_log[13]), 32'd1);
    check_eq("hs_h12", 32'(hs_log[14]), 32'd0);
    check_eq("vs_v4", 32'(vs_log[71]), 32'd0);
    check_eq("vs_v5_start", 32'(vs_log[72]), 32'd1);
    check_eq("vs_v5_end", 32'(vs_log[85]), 32'd1);
    check_eq("vs_v6", 32'(vs_log[86]), 32'd0);
    check_eq("run_fr_pulse", 32'(fr_log[86]), 32'd1);
    check_eq("run_fr_count", 32'(count(0, 1, 99)), 32'd1);
    check_eq("uf_clean", 32'(uf_log[99]), 32'd0);

    // underflow on second window pixel of frame 2 line 1
    check_eq("uf_no_pop", 32'(ren_log[116]), 32'd0);
    check_eq("uf_before", 32'(uf_log[116]), 32'd0);
    check_eq("uf_pix_prev", 32'(rgb_log[116]), 32'd9);
    check_eq("uf_pix_bg", 32'(rgb_log[117]), 32'(BG));
    check_eq("uf_pix_next", 32'(rgb_log[118]), 32'd10);
    check_eq("uf_flag", 32'(uf_log[117]), 32'd1);
    check_eq("uf_sticky", 32'(uf_log[200]), 32'd1);
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    check_eq("uf_cnt_1", 32'(cnt_log[117]), 32'd1);
`endif

    // en dropped mid-frame: frame completes, then idle
    check_eq("pops_frame2", 32'(count(1, 99, 196)), 32'd7);
    check_eq("de_frame2", 32'(count(2, 100, 197)), 32'd32);
    check_eq("vs_frame2", 32'(vs_log[170]), 32'd1);
    check_eq("no_req_en0", 32'(fr_log[184]), 32'd0);
    check_eq("idle_activity", 32'(count(3, 198, 205) + count(1, 197, 205)), 32'd0);
    check_eq("reprime_fr", 32'(fr_log[207]), 32'd1);
    check_eq("reprime_fr_count", 32'(count(0, 206, 215)), 32'd1);
    check_eq("reprime_de", 32'(count(2, 206, 216)), 32'd0);

    // third frame: pixel 16, then a second underflow, then async reset
    check_eq("f3_pix", 32'(rgb_log[234]), 32'd16);
    check_eq("f3_bg", 32'(rgb_log[235]), 32'(BG));
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    check_eq("uf_cnt_2", 32'(cnt_log[235]), 32'd2);
`endif
    rst = 1'b1;
    #1;
    check_eq("arst_rgb", 32'(rgb), 32'd0);
    check_eq("arst_de", 32'(de), 32'd0);
    check_eq("arst_hs", 32'(hs), 32'd0);
    check_eq("arst_vs", 32'(vs), 32'd0);
    check_eq("arst_fr", 32'(frame_req), 32'd0);
    check_eq("arst_uf", 32'(underflow), 32'd0);
    check_eq("arst_rd_en", 32'(rd_en), 32'd0);
`ifdef ZOOM_HDMI_UNDERFLOW_CNT_EN
    check_eq("arst_uf_cnt", 32'(underflow_cnt), 32'd0);
`endif
    #20;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
